// File: rtl/dram_rmw_ctrl_if.sv
// Load/store request and response bundle between the core and dram_rmw_ctrl.
interface dram_rmw_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // Core side: issues requests, consumes responses
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Controller side: accepts requests, produces responses
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dram_rmw_ctrl.sv
// Data-memory controller: one outstanding load/store at a time, sub-word stores
// done as read-modify-write on an internal synchronous-read array, loads
// zero/sign-extended, misaligned or illegal-size requests answered with an error.
module dram_rmw_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dram_rmw_ctrl_if.slave bus,
    output logic           busy,
    output logic [15:0]    err_count
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [1:0] FULL_SIZE = (DATA_W == 64) ? 2'b11 : 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MRG,
        S_WR,
        S_ERR,
        S_RSP
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              we_q;
    logic [IDX_W-1:0]  index_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept;
    logic              req_err;
    logic [OFF_W-1:0]  align_mask;
    logic [OFF_W+2:0]  shamt;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] read_word;
    logic [DATA_W-1:0] shifted;
    logic              lane_msb;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    assign accept         = bus.req_valid && (state == S_IDLE);
    assign bus.req_ready  = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign bus.rsp_valid  = (state == S_RSP) || (state == S_ERR);
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;

    // Classify the incoming request: illegal size or offset not aligned to the access size
    always_comb begin
        align_mask = '0;
        case (bus.req_size)
            2'b00:   align_mask = '0;
            2'b01:   align_mask = OFF_W'(1);
            2'b10:   align_mask = OFF_W'(3);
            default: align_mask = OFF_W'(7);
        endcase
        req_err = ((bus.req_size == 2'b11) && (DATA_W == 32)) ||
                  (|(bus.req_addr[OFF_W-1:0] & align_mask));
    end

    // Lane selection, load extension and store merge, all from the captured request
    always_comb begin
        shamt     = {off_q, 3'b000};
        lane_mask = '1;
        case (size_q)
            2'b00:   lane_mask = DATA_W'(8'hFF);
            2'b01:   lane_mask = DATA_W'(16'hFFFF);
            2'b10:   lane_mask = DATA_W'(32'hFFFF_FFFF);
            default: lane_mask = '1;
        endcase
        read_word = mem[index_q];
        shifted   = read_word >> shamt;
        lane_msb  = shifted[DATA_W-1];
        case (size_q)
            2'b00:   lane_msb = shifted[7];
            2'b01:   lane_msb = shifted[15];
            2'b10:   lane_msb = shifted[31];
            default: lane_msb = shifted[DATA_W-1];
        endcase
        load_ext = (shifted & lane_mask) | ({DATA_W{~uns_q & lane_msb}} & ~lane_mask);
        merged   = (rdata_q & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode: route accepted requests, then walk the access sequence
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        next_state = S_ERR;
                    else if (bus.req_we && (bus.req_size == FULL_SIZE))
                        next_state = S_WR;
                    else
                        next_state = S_RD;
                end
            end
            S_RD:         next_state = we_q ? S_MRG : S_RSP;
            S_MRG, S_WR:  next_state = S_RSP;
            S_ERR, S_RSP: if (bus.rsp_ready) next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // Request capture, read data, response registers and error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            index_q     <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                we_q        <= bus.req_we;
                index_q     <= bus.req_addr[ADDR_W-1:OFF_W];
                off_q       <= bus.req_addr[OFF_W-1:0];
                wdata_q     <= bus.req_wdata;
                size_q      <= bus.req_size;
                uns_q       <= bus.req_unsigned;
                rsp_rdata_q <= '0;
                rsp_err_q   <= req_err;
                if (req_err && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
            end
            if (state == S_RD) begin
                rdata_q <= read_word;
                if (!we_q)
                    rsp_rdata_q <= load_ext;
            end
        end
    end

    // Array write on the edge leaving MRG or WR; contents are never reset
    always_ff @(posedge clk) begin
        if (state == S_MRG)
            mem[index_q] <= merged;
        else if (state == S_WR)
            mem[index_q] <= wdata_q;
    end
endmodule

// File: tb/tb_dram_rmw_ctrl.sv
// Self-checking bench for dram_rmw_ctrl: 32-bit and 64-bit instances driven from
// a table of directed requests, plus back-pressure and mid-RMW reset sequences.
module tb_dram_rmw_ctrl;
    logic clk = 1'b0;
    logic rst;

    logic        busy32, busy64;
    logic [15:0] errc32, errc64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wide;
        bit          we;
        logic [17:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    dram_rmw_ctrl_if #(.ADDR_W(18), .DATA_W(32)) bus32 ();
    dram_rmw_ctrl_if #(.ADDR_W(18), .DATA_W(64)) bus64 ();

    dram_rmw_ctrl #(.ADDR_W(18), .DATA_W(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus32),
        .busy      (busy32),
        .err_count (errc32)
    );

    dram_rmw_ctrl #(.ADDR_W(18), .DATA_W(64)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus64),
        .busy      (busy64),
        .err_count (errc64)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    function automatic vec_t mk(bit wide, bit we, logic [17:0] addr, logic [63:0] wdata,
                                logic [1:0] size, bit uns, logic [63:0] exp_rdata,
                                bit exp_err, int exp_lat);
        vec_t v;
        v.wide = wide; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.uns = uns; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one request, wait for its response, complete the handshake and report what came back
    task automatic applyStimulus(input vec_t v, output int lat, output logic [63:0] rdata, output logic err);
        int n = 0;
        while (((v.wide ? bus64.req_ready : bus32.req_ready) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got req_ready=0, expected 1");
        end
        bus32.req_we = v.we;  bus32.req_addr = v.addr; bus32.req_wdata = v.wdata[31:0];
        bus32.req_size = v.size; bus32.req_unsigned = v.uns;
        bus64.req_we = v.we;  bus64.req_addr = v.addr; bus64.req_wdata = v.wdata;
        bus64.req_size = v.size; bus64.req_unsigned = v.uns;
        bus32.req_valid = !v.wide;
        bus64.req_valid = v.wide;
        @(posedge clk);
        @(negedge clk);
        bus32.req_valid = 1'b0;
        bus64.req_valid = 1'b0;
        lat = 1;
        while (((v.wide ? bus64.rsp_valid : bus32.rsp_valid) !== 1'b1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = v.wide ? bus64.rsp_rdata : {32'b0, bus32.rsp_rdata};
        err   = v.wide ? bus64.rsp_err : bus32.rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [63:0] rdata;
        logic        err;
        int          n;

        // Directed request table; memory word 0x10 evolves row by row
        vecs.push_back(mk(0, 1, 18'h10, 64'hDEADBEEF, 2'b10, 0, 64'h0, 0, 2));
        vecs.push_back(mk(0, 0, 18'h10, 64'h0,        2'b10, 0, 64'hDEADBEEF, 0, 2));
        vecs.push_back(mk(0, 1, 18'h11, 64'hAAAAAA5A, 2'b00, 0, 64'h0, 0, 3));
        vecs.push_back(mk(0, 1, 18'h12, 64'h1234,     2'b01, 0, 64'h0, 0, 3));
        vecs.push_back(mk(0, 0, 18'h10, 64'h0,        2'b10, 0, 64'h12345AEF, 0, 2));
        vecs.push_back(mk(0, 1, 18'h10, 64'h80FF7F01, 2'b10, 0, 64'h0, 0, 2));
        vecs.push_back(mk(0, 0, 18'h13, 64'h0,        2'b00, 0, 64'hFFFFFF80, 0, 2));
        vecs.push_back(mk(0, 0, 18'h13, 64'h0,        2'b00, 1, 64'h00000080, 0, 2));
        vecs.push_back(mk(0, 0, 18'h12, 64'h0,        2'b01, 0, 64'hFFFF80FF, 0, 2));
        vecs.push_back(mk(0, 0, 18'h12, 64'h0,        2'b01, 1, 64'h000080FF, 0, 2));
        vecs.push_back(mk(0, 0, 18'h12, 64'h0,        2'b00, 0, 64'hFFFFFFFF, 0, 2));
        vecs.push_back(mk(0, 0, 18'h11, 64'h0,        2'b00, 0, 64'h0000007F, 0, 2));
        vecs.push_back(mk(0, 0, 18'h10, 64'h0,        2'b01, 0, 64'h00007F01, 0, 2));
        vecs.push_back(mk(0, 0, 18'h11, 64'h0,        2'b01, 0, 64'h0, 1, 1));
        vecs.push_back(mk(0, 1, 18'h12, 64'h11111111, 2'b10, 0, 64'h0, 1, 1));
        vecs.push_back(mk(0, 1, 18'h10, 64'h22222222, 2'b11, 0, 64'h0, 1, 1));
        vecs.push_back(mk(0, 0, 18'h10, 64'h0,        2'b10, 0, 64'h80FF7F01, 0, 2));
        vecs.push_back(mk(0, 1, 18'h10, 64'hFFFFBEEF, 2'b01, 0, 64'h0, 0, 3));
        vecs.push_back(mk(0, 0, 18'h10, 64'h0,        2'b10, 0, 64'h80FFBEEF, 0, 2));
        vecs.push_back(mk(1, 1, 18'h08, 64'h0123456789ABCDEF, 2'b11, 0, 64'h0, 0, 2));
        vecs.push_back(mk(1, 0, 18'h0C, 64'h0, 2'b10, 0, 64'h0000000001234567, 0, 2));
        vecs.push_back(mk(1, 0, 18'h08, 64'h0, 2'b10, 0, 64'hFFFFFFFF89ABCDEF, 0, 2));
        vecs.push_back(mk(1, 0, 18'h08, 64'h0, 2'b11, 0, 64'h0123456789ABCDEF, 0, 2));
        vecs.push_back(mk(1, 1, 18'h0F, 64'h77, 2'b00, 0, 64'h0, 0, 3));
        vecs.push_back(mk(1, 0, 18'h08, 64'h0, 2'b11, 0, 64'h7723456789ABCDEF, 0, 2));
        vecs.push_back(mk(1, 0, 18'h0C, 64'h0, 2'b11, 0, 64'h0, 1, 1));
        vecs.push_back(mk(1, 0, 18'h0C, 64'h0, 2'b10, 1, 64'h0000000077234567, 0, 2));

        rst = 1'b1;
        bus32.req_valid = 1'b0; bus32.req_we = 1'b0; bus32.req_addr = '0; bus32.req_wdata = '0;
        bus32.req_size = 2'b00; bus32.req_unsigned = 1'b0; bus32.rsp_ready = 1'b1;
        bus64.req_valid = 1'b0; bus64.req_we = 1'b0; bus64.req_addr = '0; bus64.req_wdata = '0;
        bus64.req_size = 2'b00; bus64.req_unsigned = 1'b0; bus64.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_req_ready", 64'(bus32.req_ready), 64'd1);
        checkOutput("reset_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
        checkOutput("reset_rsp_rdata", 64'(bus32.rsp_rdata), 64'd0);
        checkOutput("reset_rsp_err",   64'(bus32.rsp_err), 64'd0);
        checkOutput("reset_busy",      64'(busy32), 64'd0);
        checkOutput("reset_err_count", 64'(errc32), 64'd0);
        checkOutput("reset_busy64",    64'(busy64), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], lat, rdata, err);
            checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
        end
        checkOutput("err_count32", 64'(errc32), 64'd3);
        checkOutput("err_count64", 64'(errc64), 64'd1);

        // Back-pressure: response must hold for 5 cycles with rsp_ready low
        bus32.rsp_ready = 1'b0;
        bus32.req_we = 1'b0; bus32.req_addr = 18'h10; bus32.req_size = 2'b10; bus32.req_unsigned = 1'b0;
        bus32.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.req_valid = 1'b0;
        n = 0;
        while (bus32.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp%0d_rsp_valid", k), 64'(bus32.rsp_valid), 64'd1);
            checkOutput($sformatf("bp%0d_rsp_rdata", k), 64'(bus32.rsp_rdata), 64'h80FFBEEF);
            checkOutput($sformatf("bp%0d_req_ready", k), 64'(bus32.req_ready), 64'd0);
            @(negedge clk);
        end
        bus32.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
        checkOutput("bp_release_req_ready", 64'(bus32.req_ready), 64'd1);

        // Reset during MRG of a partial store: no write, no response, outputs back to reset values
        bus32.req_we = 1'b1; bus32.req_addr = 18'h10; bus32.req_wdata = 32'h33; bus32.req_size = 2'b00;
        bus32.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("mrg_busy", 64'(busy32), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(bus32.req_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(bus32.rsp_rdata), 64'd0);
        checkOutput("rst_rsp_err",   64'(bus32.rsp_err), 64'd0);
        checkOutput("rst_busy",      64'(busy32), 64'd0);
        checkOutput("rst_err_count", 64'(errc32), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
        applyStimulus(mk(0, 0, 18'h10, 64'h0, 2'b10, 0, 64'h0, 0, 2), lat, rdata, err);
        checkOutput("post_rst_word", rdata, 64'h80FFBEEF);
        checkOutput("post_rst_latency", 64'(lat), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_rmw_ctrl.md
# dram_rmw_ctrl

Parametrised data-memory controller between the core's load/store path and an internal synchronous-read DRAM array. Accepts one request at a time over a valid/ready handshake and supports byte, half, word and (for 64-bit data) double accesses. Loads are zero- or sign-extended. Partial stores are done as a read-modify-write sequence. Misaligned or unsupported-size requests are rejected with an error response and never touch memory.

## Interface
Parameters:
- ADDR_W, 18, byte-address width.
- DATA_W, 32, memory word width; legal values 32 or 64.
- Derived: OFF_W = log2(DATA_W/8); DEPTH = 2**(ADDR_W-OFF_W) words.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (low bytes used for sub-word sizes).
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned address or illegal size.
- busy  out  1  high in any state other than IDLE.
- err_count  out  16  saturating count of error responses.

## Operation
- Request fields are captured at the accept edge, when req_valid && req_ready. They are held internally; later input changes are ignored.
- Word index = addr[ADDR_W-1:OFF_W]. Lane offset = addr[OFF_W-1:0].
- Error conditions:
  - size 11 with DATA_W=32;
  - offset not a multiple of the access size in bytes.
- States:
  - IDLE: accept → ERR if error; else WR for a full-width store; else RD.
  - RD: registers mem[index] into rdata_q. Next state is RSP for a load, MRG for a partial store.
  - MRG: writes mem[index] = rdata_q with the selected lanes replaced by the low bytes of wdata. Next state RSP.
  - WR: writes mem[index] = wdata. Next state RSP.
  - ERR: drives a one-response error with rsp_err=1, then behaves as RSP.
  - RSP (including ERR): rsp_valid=1. On rsp_valid && rsp_ready → IDLE.
- rsp_rdata and rsp_err are registered and stable while rsp_valid is high.
- Load extension:
  - The selected lane is shifted to bit 0.
  - Upper bits are 0 if req_unsigned=1; otherwise they replicate the lane's MSB.
  - A full-width load returns the word unchanged.
- err_count increments by 1 on each ERR entry. It saturates at 16'hFFFF.
- Memory contents are not initialised and are not affected by reset.

## Timing
- Reset (async assert, sync deassert edge): state=IDLE.
  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, err_count=0.
- Latency from the accept edge to the first cycle with rsp_valid=1:
  - error: 1 cycle;
  - full store: 2 cycles;
  - load: 2 cycles;
  - partial store: 3 cycles.
- The memory write occurs at the edge leaving MRG or WR.
- rst asserted before that edge: no write occurs, the request is dropped and no response is produced.
- Response back-pressure: RSP holds indefinitely while rsp_ready=0. req_ready stays 0 during that time.
- Back-to-back: a new request can be accepted in the cycle after the response handshake, giving a minimum IDLE gap of 1 cycle.
- req_valid while busy: ignored, and not latched.
- Same-word load after store: the load returns the merged data, because the write completes before IDLE.

## Test plan
- DATA_W=32:
  - Stimulus: sw 0xDEADBEEF @0x10, then lw @0x10.
  - Required: store response with rsp_err=0 at +2; load returns 0xDEADBEEF at +2.
- Sub-word store merge:
  - Stimulus: sb 0x5A @0x11, then sh 0x1234 @0x12, then lw @0x10 (memory initially 0xDEADBEEF).
  - Required: lw returns 0x12345AEF; partial-store latency is 3.
- Load extension:
  - Stimulus: lb @0x13 and lh @0x12, each signed and unsigned, with memory word 0x80FF7F01 at 0x10.
  - Required: lb signed = 0xFFFFFF80, lb unsigned = 0x00000080; lh signed = 0xFFFF80FF, lh unsigned = 0x000080FF.
- Errors (DATA_W=32):
  - Stimulus: lh @0x11, sw @0x12, size 11 @0x10.
  - Required: three responses with rsp_err=1 and rsp_rdata=0 at +1; memory unchanged; err_count=3.
- Handshake and reset:
  - Stimulus: hold rsp_ready=0 for 5 cycles; then assert rst during MRG of a partial store.
  - Required: rsp_valid and rsp_data held stable for all 5 cycles with req_ready=0; after the reset, the target word is unchanged, all outputs are at reset values and err_count=0.
- DATA_W=64:
  - Stimulus: sd 0x0123456789ABCDEF @0x8, then lw signed @0xC.
  - Required: lw returns 0x0000000001234567.
